// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the burst master.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_LAST,
    S_ABORT
  } state_t;

  // Undefined-length INCR uses the requester's count; zero still moves one beat.
  function automatic logic [7:0] burst_beats(hburst_t b, logic [7:0] len);
    case (b)
      SINGLE:         return 8'd1;
      INCR:           return (len == 8'd0) ? 8'd1 : len;
      WRAP4, INCR4:   return 8'd4;
      WRAP8, INCR8:   return 8'd8;
      default:        return 8'd16;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester after ptr_i.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);

  always_comb begin
    int idx;
    idx   = 0;
    gnt_o = '0;
    idx_o = ptr_i;
    // Walk from lowest to highest priority so the nearest requester wins last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        idx_o      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: round-robin grant, then sequences the burst's address
// phases with wrap support, wait states and two-cycle ERROR abort.
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int          NUM_REQ   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0400
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]  req_burst,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*8-1:0]  req_len,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  err,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [31:0] next_addr(logic [31:0] a, hburst_t b);
    case (b)
      WRAP4:   return {a[31:4], a[3:2] + 2'd1, 2'b00};
      WRAP8:   return {a[31:5], a[4:2] + 3'd1, 2'b00};
      WRAP16:  return {a[31:6], a[5:2] + 4'd1, 2'b00};
      default: return a + 32'd4;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic [31:0]          haddr_q, haddr_d;
  htrans_t              htrans_q, htrans_d;
  hburst_t              hburst_q, hburst_d;
  logic                 hwrite_q, hwrite_d;
  logic [7:0]           beats_q, beats_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   win;
  logic [PW-1:0]        win_idx;
  logic [31:0]          sel_addr;
  hburst_t              sel_burst;
  logic                 sel_write;
  logic [7:0]           sel_len;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win),
    .idx_o (win_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_burst = SINGLE;
    sel_write = 1'b0;
    sel_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        sel_addr  = req_addr[32*i +: 32];
        sel_burst = hburst_t'(req_burst[3*i +: 3]);
        sel_write = req_write[i];
        sel_len   = req_len[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hburst_d = hburst_q;
    hwrite_d = hwrite_q;
    beats_d  = beats_q;
    done_d   = '0;
    err_d    = 1'b0;
    gnt      = '0;
    case (state_q)
      S_IDLE: begin
        htrans_d = IDLE;
        if (|req && !HRESET) begin
          gnt      = win;
          ptr_d    = win_idx;
          owner_d  = win;
          haddr_d  = {sel_addr[31:2], 2'b00};
          hburst_d = sel_burst;
          hwrite_d = sel_write;
          beats_d  = burst_beats(sel_burst, sel_len);
          htrans_d = NONSEQ;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd1) begin
            htrans_d = IDLE;
            state_d  = S_LAST;
          end else begin
            haddr_d  = next_addr(haddr_q, hburst_q);
            htrans_d = SEQ;
          end
        end else if (HRESP) begin
          htrans_d = IDLE;
          state_d  = S_ABORT;
        end
      end
      S_LAST: begin
        if (HREADY) begin
          done_d  = owner_q;
          state_d = S_IDLE;
        end else if (HRESP) begin
          state_d = S_ABORT;
        end
      end
      default: begin
        // Second cycle of the ERROR response closes the burst early.
        htrans_d = IDLE;
        if (HREADY) begin
          done_d  = owner_q;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      haddr_q  <= BASE_ADDR;
      htrans_q <= IDLE;
      hburst_q <= SINGLE;
      hwrite_q <= 1'b0;
      beats_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      hwrite_q <= hwrite_d;
      beats_q  <= beats_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HBURST = hburst_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = HSIZE_WORD;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Bench for ahb_burst_master: directed bursts against a queue-based bus model.
module tb_ahb_burst_master;

  localparam int NR = 2;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*32-1:0] req_addr = '0;
  logic [NR*3-1:0]  req_burst = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*8-1:0]  req_len = '0;
  logic             HREADY = 1'b1;
  logic             HRESP = 1'b0;
  logic [NR-1:0]    gnt, done;
  logic             err;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [2:0]       HBURST;
  logic             HWRITE;
  logic [2:0]       HSIZE;

  ahb_burst_master #(.NUM_REQ(NR), .BASE_ADDR(32'h8000_0400)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .req_addr(req_addr),
    .req_burst(req_burst), .req_write(req_write), .req_len(req_len),
    .HREADY(HREADY), .HRESP(HRESP), .gnt(gnt), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HWRITE(HWRITE),
    .HSIZE(HSIZE)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        wr;
  } beat_t;

  typedef struct {
    logic [NR-1:0] d;
    logic          e;
  } dn_t;

  beat_t         exp_beats[$];
  dn_t           exp_done[$];
  logic [NR-1:0] exp_gnt[$];
  logic [31:0]   addr_log[$];
  logic [1:0]    trans_log[$];
  logic [NR-1:0] gnt_log[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nonseq_cyc = 0;
  int done_cyc   = 0;

  logic [31:0] t1_addr [4] = '{32'h8000_0400, 32'h8000_0404, 32'h8000_0408, 32'h8000_040C};
  logic [1:0]  t1_trans[4] = '{2'b10, 2'b11, 2'b11, 2'b11};
  logic [31:0] t2_addr [8] = '{32'h8000_0414, 32'h8000_0418, 32'h8000_041C, 32'h8000_0400,
                               32'h8000_0404, 32'h8000_0408, 32'h8000_040C, 32'h8000_0410};
  logic [31:0] t3_addr [3] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
  logic [NR-1:0] t4_gnt[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_assert++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: event missing or not expected (cycle %0d)", name, cyc);
  endtask

  // Expected address phases built from the burst rules with plain arithmetic.
  task automatic push_burst(input int who, input logic [31:0] addr, input logic [2:0] burst,
                            input logic wr, input int len, input logic e);
    int          n;
    logic [31:0] a0, base, bytes;
    bit          wrap;
    beat_t       b;
    dn_t         d;
    case (burst)
      3'd0:       n = 1;
      3'd1:       n = (len == 0) ? 1 : len;
      3'd2, 3'd3: n = 4;
      3'd4, 3'd5: n = 8;
      default:    n = 16;
    endcase
    wrap  = (burst == 3'd2) || (burst == 3'd4) || (burst == 3'd6);
    a0    = addr & 32'hFFFF_FFFC;
    bytes = 32'(n * 4);
    base  = a0 - (a0 % bytes);
    for (int k = 0; k < n; k++) begin
      b.addr  = wrap ? base + ((a0 - base + 32'(4 * k)) % bytes) : a0 + 32'(4 * k);
      b.trans = (k == 0) ? 2'b10 : 2'b11;
      b.burst = burst;
      b.wr    = wr;
      exp_beats.push_back(b);
    end
    exp_gnt.push_back(NR'(1) << who);
    d.d = NR'(1) << who;
    d.e = e;
    exp_done.push_back(d);
  endtask

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    if (!HRESET) begin
      chk("hsize", 32'(HSIZE), 32'd2);
      if (HTRANS != 2'b00) begin
        if (exp_beats.size() == 0) note_fail("unexpected_beat");
        else begin
          chk("haddr", HADDR, exp_beats[0].addr);
          chk("htrans", 32'(HTRANS), 32'(exp_beats[0].trans));
          chk("hburst", 32'(HBURST), 32'(exp_beats[0].burst));
          chk("hwrite", 32'(HWRITE), 32'(exp_beats[0].wr));
          if (HTRANS == 2'b10) nonseq_cyc = cyc;
          if (HREADY) begin
            addr_log.push_back(HADDR);
            trans_log.push_back(HTRANS);
            void'(exp_beats.pop_front());
          end
        end
      end
      if ((|done) || err) begin
        done_cyc = cyc;
        if (exp_done.size() == 0) note_fail("unexpected_done");
        else begin
          chk("done", 32'(done), 32'(exp_done[0].d));
          chk("err", 32'(err), 32'(exp_done[0].e));
          void'(exp_done.pop_front());
        end
      end
      if (|gnt) begin
        chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        gnt_log.push_back(gnt);
        if (exp_gnt.size() == 0) note_fail("unexpected_gnt");
        else begin
          chk("gnt", 32'(gnt), 32'(exp_gnt[0]));
          void'(exp_gnt.pop_front());
        end
      end
    end
  end

  task automatic issue(input int who, input logic [31:0] addr, input logic [2:0] burst,
                       input logic wr, input int len, input logic e);
    bit got;
    got = 1'b0;
    push_burst(who, addr, burst, wr, len, e);
    req_addr[32*who +: 32] = addr;
    req_burst[3*who +: 3]  = burst;
    req_write[who]         = wr;
    req_len[8*who +: 8]    = 8'(len);
    req[who]               = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge HCLK);
      if (gnt[who]) got = 1'b1;
    end
    if (!got) note_fail("gnt_timeout");
    @(posedge HCLK); #2;
    req[who] = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int c = 0; c < limit && exp_done.size() != 0; c++) @(posedge HCLK);
    if (exp_done.size() != 0) begin
      note_fail("done_timeout");
      exp_done.delete();
      exp_beats.delete();
      exp_gnt.delete();
    end
    repeat (2) @(posedge HCLK);
    #2;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    trans_log.delete();
    gnt_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;
    // Reset, with a request pending that must not be granted.
    req[0] = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_haddr", HADDR, 32'h8000_0400);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    req[0] = 1'b0;
    @(posedge HCLK); #2;
    HRESET = 1'b0;
    repeat (2) @(posedge HCLK);
    #2;

    // INCR4 from the base address.
    clear_logs();
    issue(0, 32'h8000_0400, 3'b011, 1'b0, 0, 1'b0);
    wait_done(40);
    chk("t1_nbeats", 32'(addr_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_addr%0d", k), addr_log[k], t1_addr[k]);
      chk($sformatf("t1_trans%0d", k), 32'(trans_log[k]), 32'(t1_trans[k]));
    end
    chk("t1_done_latency", 32'(done_cyc - nonseq_cyc), 32'd5);

    // WRAP8 starting mid-block.
    clear_logs();
    issue(0, 32'h8000_0414, 3'b100, 1'b1, 0, 1'b0);
    wait_done(40);
    chk("t2_nbeats", 32'(addr_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk($sformatf("t2_addr%0d", k), addr_log[k], t2_addr[k]);

    // INCR len 3 from requester 1, two wait states on beat 2.
    clear_logs();
    issue(1, 32'h0000_0100, 3'b001, 1'b1, 3, 1'b0);
    @(posedge HCLK); #2;
    HREADY = 1'b0;
    @(negedge HCLK);
    chk("t3_stall_addr_a", HADDR, 32'h0000_0104);
    chk("t3_stall_trans_a", 32'(HTRANS), 32'd3);
    @(posedge HCLK); #2;
    @(negedge HCLK);
    chk("t3_stall_addr_b", HADDR, 32'h0000_0104);
    chk("t3_stall_trans_b", 32'(HTRANS), 32'd3);
    @(posedge HCLK); #2;
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("t3_stall_addr_c", HADDR, 32'h0000_0104);
    wait_done(40);
    chk("t3_nbeats", 32'(addr_log.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("t3_addr%0d", k), addr_log[k], t3_addr[k]);

    // Both requesters held with SINGLE bursts: grants alternate.
    clear_logs();
    req_addr  = {32'h8000_0600, 32'h8000_0500};
    req_burst = {3'b000, 3'b000};
    req_write = 2'b01;
    req_len   = '0;
    push_burst(0, 32'h8000_0500, 3'b000, 1'b1, 0, 1'b0);
    push_burst(1, 32'h8000_0600, 3'b000, 1'b0, 0, 1'b0);
    push_burst(0, 32'h8000_0500, 3'b000, 1'b1, 0, 1'b0);
    push_burst(1, 32'h8000_0600, 3'b000, 1'b0, 0, 1'b0);
    req = 2'b11;
    ng = 0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      @(negedge HCLK);
      if (|gnt) ng++;
    end
    @(posedge HCLK); #2;
    req = '0;
    if (ng < 4) note_fail("t4_grant_count");
    wait_done(40);
    for (int k = 0; k < 4; k++) chk($sformatf("t4_gnt%0d", k), 32'(gnt_log[k]), 32'(t4_gnt[k]));

    // WRAP16 aborted by a two-cycle ERROR on beat 3.
    issue(0, 32'h8000_0438, 3'b110, 1'b0, 0, 1'b1);
    @(posedge HCLK); #2;
    @(posedge HCLK); #2;
    HREADY = 1'b0;
    HRESP  = 1'b1;
    @(negedge HCLK);
    chk("t5_err_beat_addr", HADDR, 32'h8000_0400);
    @(posedge HCLK); #2;
    HREADY = 1'b1;
    exp_beats.delete();
    @(negedge HCLK);
    chk("t5_idle_after_err", 32'(HTRANS), 32'd0);
    chk("t5_no_early_done", 32'(done), 32'd0);
    @(posedge HCLK); #2;
    HRESP = 1'b0;
    @(negedge HCLK);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    wait_done(10);
    repeat (6) @(posedge HCLK);
    #2;

    // Asynchronous reset in the middle of an INCR16.
    issue(0, 32'h8000_0200, 3'b111, 1'b0, 0, 1'b0);
    repeat (3) @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    #1;
    chk("t6_haddr", HADDR, 32'h8000_0400);
    chk("t6_htrans", 32'(HTRANS), 32'd0);
    chk("t6_hburst", 32'(HBURST), 32'd0);
    chk("t6_hwrite", 32'(HWRITE), 32'd0);
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    exp_beats.delete();
    exp_done.delete();
    @(posedge HCLK); #2;
    HRESET = 1'b0;
    repeat (10) @(posedge HCLK);
    @(negedge HCLK);
    chk("t6_idle_after", 32'(HTRANS), 32'd0);
    chk("t6_haddr_after", HADDR, 32'h8000_0400);
    chk("leftover_gnt", 32'(exp_gnt.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
